wbs_pdm_fader: RTL

// Fade controller for the wbs_pdm block. Software programs a target level
// per channel over a Wishbone slave port. On each programmed tick the block

---
 rtl/wbs_pdm_fader_if.sv | 25 ++
 rtl/wbs_pdm_fader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wbs_pdm_fader_if.sv
// Wishbone pipelined bus bundle. Used twice by wbs_pdm_fader: once as the
// SoC-facing slave port and once as the master port towards wbs_pdm.
interface wbs_pdm_fader_if #(
  parameter int unsigned AdrWidth = 4,
  parameter int unsigned DatWidth = 32
) ();
  logic                cyc;
  logic                stb;
  logic                we;
  logic [AdrWidth-1:0] adr;
  logic [DatWidth-1:0] dat_w;
  logic [DatWidth-1:0] dat_r;
  logic                stall;
  logic                ack;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, stall, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, stall, ack
  );
endinterface

// File: rtl/wbs_pdm_fader.sv
// Fade controller for wbs_pdm: holds a target level per channel and, on
// each tick, steps every channel's current level toward its target, issuing
// one Wishbone write to wbs_pdm per level change.
// Optional macro WBS_PDM_FADER_READBACK_EN adds a registered read mux on the
// slave port; without it slave reads return 0.
module wbs_pdm_fader #(
  parameter int unsigned BIT_RESOLUTION = 8,
  parameter int unsigned CHANNEL_NUM    = 4,
  parameter int unsigned TICK_WIDTH     = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wbs_pdm_fader_if.slave  wb,
  wbs_pdm_fader_if.master wbm,
  output logic            busy_o
);

  localparam int unsigned ChW      = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int unsigned NumSlots = 2 ** ChW;
  localparam logic [3:0]  LastCh   = 4'(CHANNEL_NUM - 1);

  typedef logic [BIT_RESOLUTION-1:0] level_t;
  typedef enum logic [1:0] {StIdle, StScan, StReq, StWait} state_e;

  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  logic                  req;
  logic                  wr;
  logic                  ack_q;
  level_t                tgt_q [NumSlots];
  level_t                cur_q [NumSlots];
  level_t                step_q;
  logic [TICK_WIDTH-1:0] period_q;
  logic [TICK_WIDTH-1:0] tick_cnt_q;
  logic                  tick;
  state_e                state_q, state_d;
  logic [3:0]            ch_q, ch_d;
  level_t                nxt_q, nxt_d;
  logic                  cur_we;
  level_t                cur_sel, tgt_sel, step_eff, diff_up, diff_dn, nxt_calc;
  logic                  unused_bits;

  // Reset asserts asynchronously, releases two clocks after wb_rst_i rises.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign req         = wb.cyc & wb.stb;
  assign wr          = req & wb.we;
  assign wb.stall    = 1'b0;
  assign wb.ack      = ack_q;
  assign unused_bits = ^{wb.dat_w, wbm.dat_r};

  // Every slave request is acked one cycle later.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= req;
  end

  // Software-visible configuration; unmapped addresses fall through untouched.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumSlots; i++) tgt_q[i] <= '0;
      step_q   <= level_t'(1);
      period_q <= '0;
    end else if (wr) begin
      if (wb.adr <= LastCh) tgt_q[wb.adr[ChW-1:0]] <= wb.dat_w[BIT_RESOLUTION-1:0];
      if (wb.adr == 4'hE)   step_q   <= wb.dat_w[BIT_RESOLUTION-1:0];
      if (wb.adr == 4'hF)   period_q <= wb.dat_w[TICK_WIDTH-1:0];
    end
  end

  assign tick = (tick_cnt_q == period_q);

  // Tick counter runs 0..period and wraps; a period write restarts it.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)                         tick_cnt_q <= '0;
    else if (wr && (wb.adr == 4'hF))    tick_cnt_q <= '0;
    else if (tick)                      tick_cnt_q <= '0;
    else                                tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Saturating step toward target: never overshoots, never wraps.
  always_comb begin
    cur_sel  = cur_q[ch_q[ChW-1:0]];
    tgt_sel  = tgt_q[ch_q[ChW-1:0]];
    step_eff = (step_q == '0) ? level_t'(1) : step_q;
    diff_up  = tgt_sel - cur_sel;
    diff_dn  = cur_sel - tgt_sel;
    if (tgt_sel > cur_sel) nxt_calc = cur_sel + ((step_eff < diff_up) ? step_eff : diff_up);
    else                   nxt_calc = cur_sel - ((step_eff < diff_dn) ? step_eff : diff_dn);
  end

  // FSM state and sweep registers.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= '0;
      nxt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      nxt_q   <= nxt_d;
    end
  end

  // Current level only moves once wbs_pdm has acked the new value.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumSlots; i++) cur_q[i] <= '0;
    end else if (cur_we) begin
      cur_q[ch_q[ChW-1:0]] <= nxt_q;
    end
  end

  // Sweep sequencing and master bus outputs.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    nxt_d     = nxt_q;
    cur_we    = 1'b0;
    wbm.cyc   = 1'b0;
    wbm.stb   = 1'b0;
    wbm.we    = 1'b0;
    wbm.adr   = '0;
    wbm.dat_w = '0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StScan;
          ch_d    = '0;
        end
      end
      StScan: begin
        if (cur_sel != tgt_sel) begin
          nxt_d   = nxt_calc;
          state_d = StReq;
        end else if (ch_q == LastCh) begin
          state_d = StIdle;
        end else begin
          ch_d = ch_q + 4'd1;
        end
      end
      StReq: begin
        wbm.cyc   = 1'b1;
        wbm.stb   = 1'b1;
        wbm.we    = 1'b1;
        wbm.adr   = ch_q;
        wbm.dat_w = 32'(nxt_q);
        if (!wbm.stall) begin
          if (wbm.ack) begin
            cur_we  = 1'b1;
            state_d = (ch_q == LastCh) ? StIdle : StScan;
            ch_d    = (ch_q == LastCh) ? ch_q : ch_q + 4'd1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        wbm.cyc   = 1'b1;
        wbm.adr   = ch_q;
        wbm.dat_w = 32'(nxt_q);
        if (wbm.ack) begin
          cur_we  = 1'b1;
          state_d = (ch_q == LastCh) ? StIdle : StScan;
          ch_d    = (ch_q == LastCh) ? ch_q : ch_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

`ifdef WBS_PDM_FADER_READBACK_EN
  logic [31:0] rd_data;
  logic [31:0] dat_r_q;
  logic [3:0]  tgt_idx;

  // Read mux; cur wins over tgt if the two windows overlap.
  always_comb begin
    rd_data = '0;
    tgt_idx = wb.adr - 4'd8;
    if (wb.adr <= LastCh) begin
      rd_data = 32'(cur_q[wb.adr[ChW-1:0]]);
    end else if ((wb.adr >= 4'd8) && (wb.adr < 4'hE) && (tgt_idx <= LastCh)) begin
      rd_data = 32'(tgt_q[tgt_idx[ChW-1:0]]);
    end else if (wb.adr == 4'hE) begin
      rd_data = 32'(step_q);
    end else if (wb.adr == 4'hF) begin
      rd_data = 32'(period_q);
    end
  end

  // Read data is registered so it lines up with ack.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)              dat_r_q <= '0;
    else if (req && !wb.we)  dat_r_q <= rd_data;
    else                     dat_r_q <= '0;
  end
  assign wb.dat_r = dat_r_q;
`else
  assign wb.dat_r = '0;
`endif

endmodule
